// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared memory-bus definitions. This package holds:
//   - the bus widths;
//   - the fetch and data request/response structs;
//   - the arbiter state and owner enums, used by mem_bus_arbiter and
//     mem_bus_arb_grant.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              ready;
    } IRequest;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
    } IResponse;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic              ready;
    } DRequest;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
    } DResponse;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        PUSH      = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_bus_arb_grant.sv
// mem_bus_arb_grant
//   Grant selection between the fetch and data ports. It also holds:
//   - the lock that freezes the grant while a request waits for
//     memreq ready;
//   - optionally, the round-robin pointer.
//
//   Build option: ARB_ROUND_ROBIN_EN
//   - Defined: a tie goes to the port that did not win the last accept.
//   - Undefined: data always beats fetch, and there is no pointer register.
//
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     ivalid      fetch request valid, already qualified by the IDLE state
//     dvalid      data request valid, already qualified by the IDLE state
//     mem_ready   memreq ready from the memory side
//     accept      a request was handed to memory this cycle
//     grant       owner_t encoding of the current winner
module mem_bus_arb_grant
    import mem_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ivalid,
    input  logic dvalid,
    input  logic mem_ready,
    input  logic accept,
    output logic grant
);

    logic   lock;
    owner_t lock_grant;
    owner_t free_grant;
    owner_t grant_int;
    logic   held_valid;

    assign held_valid = (lock_grant == OWN_D) ? dvalid : ivalid;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_winner;

    always_comb begin
        free_grant = OWN_D;
        if (ivalid && dvalid) begin
            free_grant = (last_winner == OWN_D) ? OWN_I : OWN_D;
        end else if (dvalid) begin
            free_grant = OWN_D;
        end else if (ivalid) begin
            free_grant = OWN_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= OWN_D;
        end else if (accept) begin
            last_winner <= grant_int;
        end
    end
`else
    always_comb begin
        free_grant = OWN_D;
        if (dvalid) begin
            free_grant = OWN_D;
        end else if (ivalid) begin
            free_grant = OWN_I;
        end
    end
`endif

    // A held grant is honoured only while its port keeps requesting.
    // If that port drops, the grant falls back to free selection so
    // the bus cannot be stuck on a request that is not there.
    assign grant_int = (lock && held_valid) ? lock_grant : free_grant;
    assign grant     = grant_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock       <= 1'b0;
            lock_grant <= OWN_D;
        end else if (accept) begin
            lock <= 1'b0;
        end else if ((ivalid || dvalid) && !mem_ready) begin
            lock       <= 1'b1;
            lock_grant <= grant_int;
        end else if (lock && !held_valid) begin
            lock <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between the instruction-fetch port and the
//   data-access port.
//   - At most one read is outstanding at a time.
//   - Each read response is returned to its owner through a one-cycle
//     registered push stage.
//   - Stores are fire-and-forget and produce no response.
//
//   Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration in
//   mem_bus_arb_grant. The default is fixed data-over-fetch priority.
//
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     ireq_valid/addr, ireq_ready        fetch request (ready is an output)
//     iresp_valid/addr/rdata             fetch response (outputs)
//     dreq_valid/addr/wen/wdata/wmask    data request (inputs)
//     dreq_ready                         data request ready (output)
//     dresp_valid/addr/rdata             data response (outputs)
//     memreq_valid/addr/wen/wdata/wmask  request to memory (outputs)
//     memreq_ready                       request ready from memory (input)
//     memresp_valid/addr/rdata           response from memory (inputs)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              ireq_ready,

    output logic              iresp_valid,
    output logic [ADDR_W-1:0] iresp_addr,
    output logic [DATA_W-1:0] iresp_rdata,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic              dreq_wen,
    input  logic [DATA_W-1:0] dreq_wdata,
    input  logic [MASK_W-1:0] dreq_wmask,
    output logic              dreq_ready,

    output logic              dresp_valid,
    output logic [ADDR_W-1:0] dresp_addr,
    output logic [DATA_W-1:0] dresp_rdata,

    output logic              memreq_valid,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic              memreq_wen,
    output logic [DATA_W-1:0] memreq_wdata,
    output logic [MASK_W-1:0] memreq_wmask,
    input  logic              memreq_ready,

    input  logic              memresp_valid,
    input  logic [ADDR_W-1:0] memresp_addr,
    input  logic [DATA_W-1:0] memresp_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner;
    owner_t            grant;
    logic              grant_bit;
    logic              idle;
    logic              ivalid_g;
    logic              dvalid_g;
    logic              accept;
    logic [ADDR_W-1:0] push_addr_p1;
    logic [DATA_W-1:0] push_rdata_p1;

    // rst_n is folded in here so that every request-side output is
    // forced to 0 while reset is held, whatever memreq_ready does.
    assign idle     = rst_n && (state == IDLE);
    assign ivalid_g = idle && ireq_valid;
    assign dvalid_g = idle && dreq_valid;

    mem_bus_arb_grant u_grant (
        .clk       (clk),
        .rst_n     (rst_n),
        .ivalid    (ivalid_g),
        .dvalid    (dvalid_g),
        .mem_ready (memreq_ready),
        .accept    (accept),
        .grant     (grant_bit)
    );

    assign grant = owner_t'(grant_bit);

    always_comb begin
        state_nxt    = state;
        memreq_valid = 1'b0;
        memreq_addr  = '0;
        memreq_wen   = 1'b0;
        memreq_wdata = '0;
        memreq_wmask = '0;
        ireq_ready   = 1'b0;
        dreq_ready   = 1'b0;
        accept       = 1'b0;

        case (state)
            IDLE: begin
                if (idle) begin
                    memreq_valid = ivalid_g || dvalid_g;
                    if (grant == OWN_D) begin
                        memreq_addr  = dreq_addr;
                        memreq_wen   = dreq_wen;
                        memreq_wdata = dreq_wdata;
                        memreq_wmask = dreq_wmask;
                        dreq_ready   = memreq_ready;
                    end else begin
                        memreq_addr  = ireq_addr;
                        ireq_ready   = memreq_ready;
                    end
                    accept = memreq_valid && memreq_ready;
                    // A store stays in IDLE. Only a read waits for data.
                    if (accept && !memreq_wen) begin
                        state_nxt = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (memresp_valid) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_D;
        end else begin
            state <= state_nxt;
            if (accept && !memreq_wen) begin
                owner <= grant;
            end
        end
    end

    // ---- push stage: memory response registered for one cycle ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_addr_p1  <= '0;
            push_rdata_p1 <= '0;
        end else if ((state == WAIT_RESP) && memresp_valid) begin
            push_addr_p1  <= memresp_addr;
            push_rdata_p1 <= memresp_rdata;
        end
    end

    assign iresp_valid = (state == PUSH) && (owner == OWN_I);
    assign dresp_valid = (state == PUSH) && (owner == OWN_D);
    assign iresp_addr  = push_addr_p1;
    assign iresp_rdata = push_rdata_p1;
    assign dresp_addr  = push_addr_p1;
    assign dresp_rdata = push_rdata_p1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_addr;
    logic [31:0] iresp_rdata;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic        dreq_wen;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wmask;
    logic        dreq_ready;
    logic        dresp_valid;
    logic [31:0] dresp_addr;
    logic [31:0] dresp_rdata;
    logic        memreq_valid;
    logic [31:0] memreq_addr;
    logic        memreq_wen;
    logic [31:0] memreq_wdata;
    logic [3:0]  memreq_wmask;
    logic        memreq_ready;
    logic        memresp_valid;
    logic [31:0] memresp_addr;
    logic [31:0] memresp_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_ready    (ireq_ready),
        .iresp_valid   (iresp_valid),
        .iresp_addr    (iresp_addr),
        .iresp_rdata   (iresp_rdata),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_wen      (dreq_wen),
        .dreq_wdata    (dreq_wdata),
        .dreq_wmask    (dreq_wmask),
        .dreq_ready    (dreq_ready),
        .dresp_valid   (dresp_valid),
        .dresp_addr    (dresp_addr),
        .dresp_rdata   (dresp_rdata),
        .memreq_valid  (memreq_valid),
        .memreq_addr   (memreq_addr),
        .memreq_wen    (memreq_wen),
        .memreq_wdata  (memreq_wdata),
        .memreq_wmask  (memreq_wmask),
        .memreq_ready  (memreq_ready),
        .memresp_valid (memresp_valid),
        .memresp_addr  (memresp_addr),
        .memresp_rdata (memresp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ireq_valid    = 1'b1;
        ireq_addr     = 32'h0000_0100;
        dreq_valid    = 1'b0;
        dreq_addr     = '0;
        dreq_wen      = 1'b0;
        dreq_wdata    = '0;
        dreq_wmask    = '0;
        memreq_ready  = 1'b1;
        memresp_valid = 1'b0;
        memresp_addr  = '0;
        memresp_rdata = '0;

        // Reset: outputs quiet even with a request and ready present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memreq_valid", 32'(memreq_valid), 32'd0);
        chk("rst_memreq_addr",  memreq_addr, 32'd0);
        chk("rst_ireq_ready",   32'(ireq_ready), 32'd0);
        chk("rst_dreq_ready",   32'(dreq_ready), 32'd0);
        chk("rst_iresp_valid",  32'(iresp_valid), 32'd0);
        chk("rst_dresp_valid",  32'(dresp_valid), 32'd0);
        chk("rst_state",        32'(dut.state), 32'(IDLE));
        ireq_valid = 1'b0;
        rst_n      = 1'b1;
        cyc();

        // Test 1: fetch read 0x100, response 2 cycles after accept
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_0100;
        #1;
        chk("t1_memreq_valid", 32'(memreq_valid), 32'd1);
        chk("t1_memreq_addr",  memreq_addr, 32'h100);
        chk("t1_memreq_wen",   32'(memreq_wen), 32'd0);
        chk("t1_ireq_ready",   32'(ireq_ready), 32'd1);
        chk("t1_dreq_ready",   32'(dreq_ready), 32'd0);
        cyc();                                  // T+1
        ireq_valid = 1'b0;
        #1;
        chk("t1_wait_memreq_valid", 32'(memreq_valid), 32'd0);
        chk("t1_wait_state", 32'(dut.state), 32'(WAIT_RESP));
        cyc();                                  // T+2
        memresp_valid = 1'b1;
        memresp_addr  = 32'h100;
        memresp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_iresp_early", 32'(iresp_valid), 32'd0);
        cyc();                                  // T+3
        memresp_valid = 1'b0;
        #1;
        chk("t1_iresp_valid", 32'(iresp_valid), 32'd1);
        chk("t1_iresp_addr",  iresp_addr, 32'h100);
        chk("t1_iresp_rdata", iresp_rdata, 32'hDEAD_BEEF);
        chk("t1_dresp_valid", 32'(dresp_valid), 32'd0);
        cyc();                                  // T+4
        chk("t1_iresp_one_cycle", 32'(iresp_valid), 32'd0);
        chk("t1_back_idle", 32'(dut.state), 32'(IDLE));

        // Test 2: simultaneous fetch 0x100 and data read 0x200
        ireq_valid = 1'b1;
        ireq_addr  = 32'h100;
        dreq_valid = 1'b1;
        dreq_addr  = 32'h200;
        dreq_wen   = 1'b0;
        #1;
        chk("t2_first_addr",  memreq_addr, 32'h200);
        chk("t2_dreq_ready",  32'(dreq_ready), 32'd1);
        chk("t2_ireq_ready",  32'(ireq_ready), 32'd0);
        cyc();
        dreq_valid    = 1'b0;
        memresp_valid = 1'b1;
        memresp_addr  = 32'h200;
        memresp_rdata = 32'h1111_2222;
        #1;
        chk("t2_wait_ireq_ready", 32'(ireq_ready), 32'd0);
        cyc();
        memresp_valid = 1'b0;
        #1;
        chk("t2_dresp_valid", 32'(dresp_valid), 32'd1);
        chk("t2_dresp_rdata", dresp_rdata, 32'h1111_2222);
        chk("t2_dresp_addr",  dresp_addr, 32'h200);
        chk("t2_iresp_quiet", 32'(iresp_valid), 32'd0);
        chk("t2_push_no_accept", 32'(ireq_ready), 32'd0);
        chk("t2_push_memreq",    32'(memreq_valid), 32'd0);
        cyc();
        chk("t2_second_addr", memreq_addr, 32'h100);
        chk("t2_second_ready", 32'(ireq_ready), 32'd1);
        cyc();
        ireq_valid    = 1'b0;
        memresp_valid = 1'b1;
        memresp_addr  = 32'h100;
        memresp_rdata = 32'h3333_4444;
        cyc();
        memresp_valid = 1'b0;
        #1;
        chk("t2_iresp_valid", 32'(iresp_valid), 32'd1);
        chk("t2_iresp_rdata", iresp_rdata, 32'h3333_4444);
        chk("t2_dresp_quiet", 32'(dresp_valid), 32'd0);
        cyc();

        // Test 3: lock holds fetch while memreq_ready is low
        memreq_ready = 1'b0;
        ireq_valid   = 1'b1;
        ireq_addr    = 32'h100;
        #1;
        chk("t3_c1_addr",  memreq_addr, 32'h100);
        chk("t3_c1_ready", 32'(ireq_ready), 32'd0);
        cyc();
        dreq_valid = 1'b1;
        dreq_addr  = 32'h200;
        dreq_wen   = 1'b0;
        #1;
        chk("t3_c2_addr_locked", memreq_addr, 32'h100);
        chk("t3_c2_dreq_ready",  32'(dreq_ready), 32'd0);
        cyc();
        chk("t3_c3_addr_locked", memreq_addr, 32'h100);
        cyc();
        memreq_ready = 1'b1;
        #1;
        chk("t3_c4_addr",  memreq_addr, 32'h100);
        chk("t3_c4_ready", 32'(ireq_ready), 32'd1);
        cyc();
        ireq_valid    = 1'b0;
        memresp_valid = 1'b1;
        memresp_addr  = 32'h100;
        memresp_rdata = 32'h0000_0055;
        cyc();
        memresp_valid = 1'b0;
        #1;
        chk("t3_iresp_valid", 32'(iresp_valid), 32'd1);
        chk("t3_iresp_rdata", iresp_rdata, 32'h55);
        cyc();
        chk("t3_d_after_addr",  memreq_addr, 32'h200);
        chk("t3_d_after_ready", 32'(dreq_ready), 32'd1);
        cyc();
        dreq_valid    = 1'b0;
        memresp_valid = 1'b1;
        memresp_addr  = 32'h200;
        memresp_rdata = 32'h0000_0066;
        cyc();
        memresp_valid = 1'b0;
        #1;
        chk("t3_dresp_valid", 32'(dresp_valid), 32'd1);
        chk("t3_dresp_rdata", dresp_rdata, 32'h66);
        cyc();

        // Test 4: three back-to-back stores
        dreq_valid = 1'b1;
        dreq_wen   = 1'b1;
        dreq_wmask = 4'hF;
        dreq_addr  = 32'h10;
        dreq_wdata = 32'hA0A0_0010;
        #1;
        chk("t4_s0_ready", 32'(dreq_ready), 32'd1);
        chk("t4_s0_wen",   32'(memreq_wen), 32'd1);
        chk("t4_s0_wdata", memreq_wdata, 32'hA0A0_0010);
        chk("t4_s0_wmask", 32'(memreq_wmask), 32'hF);
        cyc();
        dreq_addr  = 32'h14;
        dreq_wdata = 32'hA0A0_0014;
        #1;
        chk("t4_s1_state", 32'(dut.state), 32'(IDLE));
        chk("t4_s1_ready", 32'(dreq_ready), 32'd1);
        chk("t4_s1_addr",  memreq_addr, 32'h14);
        cyc();
        dreq_addr  = 32'h18;
        dreq_wdata = 32'hA0A0_0018;
        #1;
        chk("t4_s2_state", 32'(dut.state), 32'(IDLE));
        chk("t4_s2_ready", 32'(dreq_ready), 32'd1);
        chk("t4_s2_addr",  memreq_addr, 32'h18);
        cyc();
        dreq_valid = 1'b0;
        dreq_wen   = 1'b0;
        #1;
        chk("t4_end_state", 32'(dut.state), 32'(IDLE));
        chk("t4_iresp",     32'(iresp_valid), 32'd0);
        chk("t4_dresp",     32'(dresp_valid), 32'd0);
        cyc();

        // Test 5: reset during WAIT_RESP, late response ignored
        ireq_valid = 1'b1;
        ireq_addr  = 32'h100;
        cyc();
        ireq_valid = 1'b0;
        #1;
        chk("t5_in_wait", 32'(dut.state), 32'(WAIT_RESP));
        rst_n = 1'b0;
        cyc();
        rst_n         = 1'b1;
        memresp_valid = 1'b1;
        memresp_addr  = 32'h100;
        memresp_rdata = 32'hBAD0_BAD0;
        #1;
        chk("t5_state_idle", 32'(dut.state), 32'(IDLE));
        cyc();
        memresp_valid = 1'b0;
        #1;
        chk("t5_iresp", 32'(iresp_valid), 32'd0);
        chk("t5_dresp", 32'(dresp_valid), 32'd0);
        chk("t5_state_after", 32'(dut.state), 32'(IDLE));
        cyc();

`ifdef ARB_ROUND_ROBIN_EN
        // Test 6: round-robin alternation. A lone fetch read first makes
        // the pointer's last winner I, so the contended sequence starts at D.
        ireq_valid = 1'b1;
        ireq_addr  = 32'h100;
        cyc();
        ireq_valid    = 1'b0;
        memresp_valid = 1'b1;
        cyc();
        memresp_valid = 1'b0;
        cyc();
        ireq_valid = 1'b1;
        dreq_valid = 1'b1;
        dreq_wen   = 1'b0;
        dreq_addr  = 32'h200;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t6_rr_addr", memreq_addr, (n % 2 == 0) ? 32'h200 : 32'h100);
            cyc();
            memresp_valid = 1'b1;
            cyc();
            memresp_valid = 1'b0;
            cyc();
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
